// File: rtl/score_pkg.sv
// Shared constants and FSM encoding for the high-score submission path.
package score_pkg;

   localparam int SCORE_WIDTH = 7;
   localparam int PID_W       = 3;
   localparam int MAX_PLAYERS = 7;
   localparam int RAM_LATENCY = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/score_submit_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, ascending, wrapping.
module rr_arbiter
   import score_pkg::*;
#(
   parameter int N = 5
) (
   input  logic [N-1:0]     req,
   input  logic [PID_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PID_W-1:0] id,
   output logic             valid
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   always_comb begin
      int               sum;
      logic [IDX_W-1:0] idx;
      grant = '0;
      id    = '0;
      valid = 1'b0;
      sum   = 0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         sum = int'(ptr) + k;
         if (sum >= N) sum = sum - N;
         idx = IDX_W'(sum);
         if (!valid && req[idx]) begin
            valid      = 1'b1;
            grant[idx] = 1'b1;
            id         = PID_W'(sum);
         end
      end
   end

endmodule

// File: rtl/score_submit_arbiter.sv
// Shares the single score-RAM port among N_PLAYERS stations: round-robin grant,
// hold ID/score through the RAM update, then a one-cycle ack to the winner.
module score_submit_arbiter
   import score_pkg::*;
#(
   parameter int N_PLAYERS = 5,
   parameter int SCORE_W   = SCORE_WIDTH,
   parameter int RAM_LAT   = RAM_LATENCY
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [N_PLAYERS-1:0]         req,
   input  logic [N_PLAYERS*SCORE_W-1:0] score_in,
   output logic [N_PLAYERS-1:0]         ack,
   output logic                         ram_enable,
   output logic [PID_W-1:0]             ram_player_id,
   output logic [SCORE_W-1:0]           ram_score,
   output logic                         busy,
   output logic [PID_W-1:0]             grant_id
);

   localparam int CNT_W = $clog2(RAM_LAT + 1);

   arb_state_e             state_q, state_d;
   logic [PID_W-1:0]       id_q, id_d;
   logic [SCORE_W-1:0]     score_q, score_d;
   logic [PID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [N_PLAYERS-1:0]         win_grant;
   logic [PID_W-1:0]             win_id;
   logic                         win_valid;
   logic [SCORE_W-1:0]           win_score;
   logic [N_PLAYERS*SCORE_W-1:0] score_masked;

   rr_arbiter #(.N(N_PLAYERS)) u_rr_arbiter (
      .req   (req),
      .ptr   (rr_ptr_q),
      .grant (win_grant),
      .id    (win_id),
      .valid (win_valid)
   );

   // One-hot grant selects the winner's score slice; ack follows the serviced ID.
   for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
      assign score_masked[gi*SCORE_W +: SCORE_W] =
         score_in[gi*SCORE_W +: SCORE_W] & {SCORE_W{win_grant[gi]}};
      assign ack[gi] = (state_q == ST_ACK) && (id_q == PID_W'(gi));
   end

   always_comb begin
      win_score = '0;
      for (int k = 0; k < N_PLAYERS; k++) begin
         win_score = win_score | score_masked[k*SCORE_W +: SCORE_W];
      end
   end

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      score_d  = score_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               id_d    = win_id;
               score_d = win_score;
               state_d = ST_ISSUE;
            end
         end
         // WAIT spans RAM_LAT+1 cycles so ack lands RAM_LAT+2 cycles after enable.
         ST_ISSUE: begin
            cnt_d   = CNT_W'(RAM_LAT);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_ACK;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_ACK: begin
            rr_ptr_d = (id_q == PID_W'(N_PLAYERS - 1)) ? '0 : id_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         id_q     <= '0;
         score_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         score_q  <= score_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ram_enable    = (state_q == ST_ISSUE);
   assign busy          = (state_q != ST_IDLE);
   assign ram_player_id = id_q;
   assign grant_id      = id_q;
   assign ram_score     = score_q;

endmodule

// File: tb/tb_score_submit_arbiter.sv
// Directed + randomized bench for score_submit_arbiter against a transaction-level model.
module tb_score_submit_arbiter;

   localparam int N   = 5;
   localparam int SW  = 7;
   localparam int LAT = 3;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [N-1:0]  req;
   logic [N*SW-1:0] score_in;
   logic [N-1:0]  ack;
   logic          ram_enable;
   logic [2:0]    ram_player_id;
   logic [SW-1:0] ram_score;
   logic          busy;
   logic [2:0]    grant_id;

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;   // model: player with highest priority next arbitration
   int last_w = -1;

   always #5 Clk = ~Clk;

   score_submit_arbiter #(.N_PLAYERS(N), .SCORE_W(SW), .RAM_LAT(LAT)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .req           (req),
      .score_in      (score_in),
      .ack           (ack),
      .ram_enable    (ram_enable),
      .ram_player_id (ram_player_id),
      .ram_score     (ram_score),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SW-1:0] get_score(input int p);
      return score_in[p*SW +: SW];
   endfunction

   task automatic set_score(input int p, input logic [SW-1:0] v);
      score_in[p*SW +: SW] = v;
   endtask

   // Winner = requesting player with the smallest circular distance from ptr.
   function automatic int model_winner(input logic [N-1:0] r, input int p);
      int best  = -1;
      int bestd = N;
      for (int i = 0; i < N; i++) begin
         if (r[i] && ((i - p + N) % N) < bestd) begin
            bestd = (i - p + N) % N;
            best  = i;
         end
      end
      return best;
   endfunction

   // Called at a negedge with the DUT idle and req != 0.
   task automatic round(input bit keep_req, input bit scramble, input bit drop_mid, input bit do_abort);
      int            w;
      logic [SW-1:0] s;
      bit            got;
      check("idle_busy", busy, 0);
      w = model_winner(req, ptr_m);
      s = get_score(w);
      @(negedge Clk);
      check("issue_enable", ram_enable, 1);
      check("issue_id", ram_player_id, w);
      check("issue_grant", grant_id, w);
      check("issue_score", ram_score, s);
      check("issue_busy", busy, 1);
      check("issue_ack", ack, 0);
      if (scramble) for (int i = 0; i < N; i++) set_score(i, get_score(i) + 7'd54);
      if (drop_mid) req[w] = 1'b0;
      got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         @(negedge Clk);
         if (do_abort && k == 2) begin
            check("pre_abort_ack", ack, 0);
            Reset = 1'b0;
            @(negedge Clk);
            check("abort_busy", busy, 0);
            check("abort_ack", ack, 0);
            check("abort_enable", ram_enable, 0);
            check("abort_id", ram_player_id, 0);
            check("abort_score", ram_score, 0);
            Reset  = 1'b1;
            ptr_m  = 0;
            last_w = -1;
            $display("txn: player %0d score %0d aborted by reset", w, s);
            return;
         end
         if (ack !== '0) begin
            got = 1'b1;
            check("ack_latency", k, LAT + 2);
            check("ack_vector", ack, 1 << w);
            check("ack_enable", ram_enable, 0);
            $display("txn: player %0d score %0d ack after %0d cycles", w, s, k);
         end else if (k == 1) begin
            check("wait_enable", ram_enable, 0);
            check("wait_id", ram_player_id, w);
            check("wait_score", ram_score, s);
         end
      end
      check("ack_seen", got, 1);
      ptr_m  = (w + 1) % N;
      last_w = w;
      if (!keep_req) req[w] = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      Reset    = 1'b0;
      req      = '1;
      score_in = '0;
      for (int i = 0; i < N; i++) set_score(i, 7'($urandom_range(0, 127)));
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         check("rst_busy", busy, 0);
         check("rst_enable", ram_enable, 0);
         check("rst_ack", ack, 0);
         check("rst_id", ram_player_id, 0);
         check("rst_grant", grant_id, 0);
         check("rst_score", ram_score, 0);
      end
      Reset = 1'b1;
      req   = '0;
      @(negedge Clk);
      check("idle_no_req_busy", busy, 0);
      check("idle_no_req_enable", ram_enable, 0);

      // Contention: held requests, expected order 0,1,4,0
      req = 5'b10011;
      round(1, 0, 0, 0); check("cont_first", last_w, 0);
      round(1, 0, 0, 0); check("cont_second", last_w, 1);
      round(1, 0, 0, 0); check("cont_third", last_w, 4);
      round(1, 0, 0, 0); check("cont_fourth", last_w, 0);
      req = '0;

      // Single submission
      set_score(2, 7'd45);
      req = 5'b00100;
      round(0, 0, 0, 0); check("single_winner", last_w, 2);

      // Wrap after servicing player 4
      req = 5'b10000;
      round(0, 0, 0, 0);
      req = 5'b10001;
      round(0, 0, 0, 0); check("wrap_winner", last_w, 0);
      round(0, 0, 0, 0); check("wrap_second", last_w, 4);

      // Score change 45 -> 99 during WAIT, requester drops req mid-transaction
      set_score(1, 7'd45);
      req = 5'b00010;
      round(0, 1, 1, 0); check("stable_winner", last_w, 1);
      check("stable_new_score", get_score(1), 99);

      // Abort during WAIT, then the same request is serviced cleanly
      req = 5'b00001;
      round(0, 0, 0, 1);
      round(0, 0, 0, 0); check("after_abort_winner", last_w, 0);

      // Randomized submissions
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            req = '0;
            @(negedge Clk);
            check("rand_idle_enable", ram_enable, 0);
            check("rand_idle_busy", busy, 0);
         end
         for (int i = 0; i < N; i++) if (!req[i]) set_score(i, 7'($urandom_range(0, 127)));
         req = req | N'($urandom_range(0, (1 << N) - 1));
         if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
         round($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
